// File: rtl/udp_tx_sched.sv
`timescale 1ns/1ps
// Two-channel packet scheduler feeding a UDP TX engine: round-robin picks a
// channel whose FIFO holds a full packet, streams it word by word, then idles.
module udp_tx_sched #(
    parameter int PKT_BYTES      = 1024,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int LVL_W          = 10
) (
    input  logic             gmii_tx_clk,
    input  logic             sys_rst,
    input  logic [1:0]       ch_en,
    input  logic [LVL_W-1:0] ch0_level,
    input  logic [LVL_W-1:0] ch1_level,
    input  logic [31:0]      ch0_rd_data,
    input  logic [31:0]      ch1_rd_data,
    output logic             ch0_rd_en,
    output logic             ch1_rd_en,
    input  logic             tx_req,
    input  logic             tx_done,
    output logic             tx_start_en,
    output logic [15:0]      tx_byte_num,
    output logic [31:0]      tx_data,
    output logic             busy,
    output logic             grant_ch,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1,
    output logic [7:0]       timeout_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WORDS    = PKT_BYTES / 4;
    localparam int GAP_HOLD = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int WC_W     = $clog2(WORDS + 1);
    localparam int GC_W     = $clog2(GAP_HOLD + 1);
    localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [LVL_W:0] WORDS_LVL = (LVL_W + 1)'(WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      r_elig;
    logic            r_grant;
    logic [WC_W-1:0] r_word_cnt;
    logic [GC_W-1:0] r_gap_cnt;
    logic [WD_W-1:0] r_wdog;
    logic [15:0]     r_pkt_cnt0;
    logic [15:0]     r_pkt_cnt1;
    logic [7:0]      r_timeout_cnt;

    logic [1:0]      w_state_nxt;
    logic [1:0]      w_elig;
    logic            w_next_grant;
    logic            w_in_send;
    logic            w_fwd;
    logic            w_timeout;
    logic            w_done;
    logic            w_gap_end;

    assign w_elig[0] = ch_en[0] && ({1'b0, ch0_level} >= WORDS_LVL);
    assign w_elig[1] = ch_en[1] && ({1'b0, ch1_level} >= WORDS_LVL);

    // Tie goes to the channel that did not send last; grant_ch resets to 1 so ch0 wins first.
    assign w_next_grant = (&r_elig) ? ~r_grant : r_elig[1];

    assign w_in_send = (r_state == S_SEND);
    assign w_fwd     = w_in_send && tx_req && (r_word_cnt < WC_W'(WORDS));
    assign w_done    = w_in_send && tx_done;
    assign w_timeout = w_in_send && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_gap_end = (r_state == S_GAP) && (r_gap_cnt == GC_W'(GAP_HOLD - 1));

    assign ch0_rd_en   = w_fwd && !r_grant;
    assign ch1_rd_en   = w_fwd &&  r_grant;
    assign tx_data     = w_in_send ? (r_grant ? ch1_rd_data : ch0_rd_data) : 32'd0;
    assign tx_start_en = (r_state == S_START);
    assign tx_byte_num = 16'(PKT_BYTES);
    assign busy        = (r_state != S_IDLE);
    assign grant_ch    = r_grant;
    assign pkt_cnt0    = r_pkt_cnt0;
    assign pkt_cnt1    = r_pkt_cnt1;
    assign timeout_cnt = r_timeout_cnt;
    assign dbg_state   = r_state;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|r_elig) w_state_nxt = S_START;
            S_START: w_state_nxt = S_SEND;
            S_SEND:  if (tx_done || w_timeout) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Eligibility is registered once, so the start pulse lands two edges after it is seen.
    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_elig        <= 2'b00;
            r_grant       <= 1'b1;
            r_word_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_wdog        <= '0;
            r_pkt_cnt0    <= 16'd0;
            r_pkt_cnt1    <= 16'd0;
            r_timeout_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_elig  <= w_elig;

            if ((r_state == S_IDLE) && (|r_elig)) begin
                r_grant <= w_next_grant;
            end

            if (r_state == S_START) begin
                r_word_cnt <= '0;
            end else if (w_fwd) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            if (r_state == S_START) begin
                r_wdog <= '0;
            end else if (w_in_send) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            // A completion in the same cycle as the watchdog expiry wins.
            if (w_done) begin
                if (r_grant) begin
                    r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
                end else begin
                    r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
                end
            end else if (w_timeout && (r_timeout_cnt != 8'hFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
        end
    end

    a_rd_exclusive: assert property (@(posedge gmii_tx_clk) disable iff (sys_rst)
        !(ch0_rd_en && ch1_rd_en));

    a_start_single: assert property (@(posedge gmii_tx_clk) disable iff (sys_rst)
        tx_start_en |=> !tx_start_en);

    a_word_bound: assert property (@(posedge gmii_tx_clk) disable iff (sys_rst)
        r_word_cnt <= WC_W'(WORDS));

endmodule

// File: tb/tb_udp_tx_sched.sv
`timescale 1ns/1ps
// Bench for udp_tx_sched: main instance with default timing, second instance
// with a short watchdog for abort and saturation behaviour.
module tb_udp_tx_sched;

    localparam int WORDS = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst, rd0, rd1, tx_req, tx_done, start, busy, grant;
    logic [1:0]  ch_en, st;
    logic [9:0]  lvl0, lvl1;
    logic [31:0] rdd0, rdd1, txd;
    logic [15:0] byte_num, pc0, pc1;
    logic [7:0]  to_cnt;

    // Short-watchdog instance signals
    logic        b_rst, b_rd0, b_rd1, b_tx_req, b_tx_done, b_start, b_busy, b_grant;
    logic [1:0]  b_en, b_st;
    logic [9:0]  b_lvl0, b_lvl1;
    logic [31:0] b_txd;
    logic [15:0] b_byte_num, b_pc0, b_pc1;
    logic [7:0]  b_to;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];
    logic [0:0]  exp_start_q[$];

    int f0_ptr = 0, f1_ptr = 0, sent0 = 0, sent1 = 0, rd0_cnt = 0, rd1_cnt = 0;

    udp_tx_sched dut (
        .gmii_tx_clk(clk), .sys_rst(rst), .ch_en(ch_en),
        .ch0_level(lvl0), .ch1_level(lvl1),
        .ch0_rd_data(rdd0), .ch1_rd_data(rdd1),
        .ch0_rd_en(rd0), .ch1_rd_en(rd1),
        .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(start),
        .tx_byte_num(byte_num), .tx_data(txd), .busy(busy), .grant_ch(grant),
        .pkt_cnt0(pc0), .pkt_cnt1(pc1), .timeout_cnt(to_cnt), .dbg_state(st)
    );

    udp_tx_sched #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_b (
        .gmii_tx_clk(clk), .sys_rst(b_rst), .ch_en(b_en),
        .ch0_level(b_lvl0), .ch1_level(b_lvl1),
        .ch0_rd_data(32'h1111_0000), .ch1_rd_data(32'h2222_0000),
        .ch0_rd_en(b_rd0), .ch1_rd_en(b_rd1),
        .tx_req(b_tx_req), .tx_done(b_tx_done), .tx_start_en(b_start),
        .tx_byte_num(b_byte_num), .tx_data(b_txd), .busy(b_busy), .grant_ch(b_grant),
        .pkt_cnt0(b_pc0), .pkt_cnt1(b_pc1), .timeout_cnt(b_to), .dbg_state(b_st)
    );

    // Channel FIFO model: each word carries a channel tag and its pop index.
    assign rdd0 = 32'hC000_0000 + 32'(f0_ptr);
    assign rdd1 = 32'hD100_0000 + 32'(f1_ptr);

    always @(posedge clk) begin
        if (rd0) f0_ptr <= f0_ptr + 1;
        if (rd1) f1_ptr <= f1_ptr + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got unexpected event or expired wait, required none", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents a start or a read.
    always @(negedge clk) begin
        logic        e_g;
        logic [32:0] e_w;
        if (start) begin
            if (exp_start_q.size() == 0) fail_evt("start_unexpected");
            else begin
                e_g = exp_start_q.pop_front();
                check("start_grant", 64'(grant), 64'(e_g));
            end
        end
        if (rd0 && rd1) fail_evt("rd_both");
        else if (rd0 || rd1) begin
            if (rd0) rd0_cnt++;
            if (rd1) rd1_cnt++;
            if (exp_q.size() == 0) fail_evt("rd_unexpected");
            else begin
                e_w = exp_q.pop_front();
                check("rd_word", 64'({rd1, txd}), 64'(e_w));
            end
        end
        if (b_rd0 || b_rd1) fail_evt("b_rd_unexpected");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("start_wait");
    endtask

    task automatic wait_start_b();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (b_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_evt("b_start_wait");
    endtask

    task automatic push_word(input int ch);
        if (ch == 0) begin
            exp_q.push_back({1'b0, 32'hC000_0000 + 32'(sent0)});
            sent0++;
        end else begin
            exp_q.push_back({1'b1, 32'hD100_0000 + 32'(sent1)});
            sent1++;
        end
    endtask

    // Called in the START cycle; plays the UDP engine for one packet.
    task automatic engine(input int ch, input int n_req, input bit done);
        tick();
        for (int i = 0; i < n_req; i++) begin
            tx_req = 1'b1;
            if (i < WORDS) push_word(ch);
            tick();
        end
        tx_req = 1'b0;
        if (done) begin
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic send_pkt(input int ch);
        exp_start_q.push_back(1'(ch));
        wait_start();
        engine(ch, WORDS, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 64'(start), 64'(0));
        check({tag, "_rd"}, 64'({rd1, rd0}), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_grant"}, 64'(grant), 64'(1));
        check({tag, "_cnts"}, 64'({pc1, pc0, to_cnt}), 64'(0));
        check({tag, "_txdata"}, 64'(txd), 64'(0));
        check({tag, "_state"}, 64'(st), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, c;
        logic [1:0] prev;
        rst = 1'b1; ch_en = 2'b00; lvl0 = '0; lvl1 = '0; tx_req = 1'b0; tx_done = 1'b0;
        b_rst = 1'b1; b_en = 2'b00; b_lvl0 = '0; b_lvl1 = '0; b_tx_req = 1'b0; b_tx_done = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        check("byte_num", 64'(byte_num), 64'(1024));
        rst = 1'b0;
        tick(2);

        // Threshold: one word short never starts; exactly a packet starts two edges later
        lvl0 = 10'd255; ch_en = 2'b01;
        tick(20);
        check("thr255_busy", 64'(busy), 64'(0));
        lvl0 = 10'd256;
        exp_start_q.push_back(1'b0);
        tick();
        check("thr_edge1", 64'(start), 64'(0));
        tick();
        check("thr_edge2", 64'(start), 64'(1));
        engine(0, WORDS, 1'b1);
        check("pkt1_cnt0", 64'(pc0), 64'(1));
        check("pkt1_gap_state", 64'(st), 64'(3));

        // Start spacing after tx_done with the channel still eligible
        exp_start_q.push_back(1'b0);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (start) begin
                n = i;
                break;
            end
        end
        check("gap_to_start", 64'(n), 64'(65));

        // Over-read, with the channel disabled while the packet is in flight
        ch_en = 2'b00;
        c = rd0_cnt;
        engine(0, WORDS + 4, 1'b1);
        check("overread_rd", 64'(rd0_cnt - c), 64'(WORDS));
        check("pkt2_cnt0", 64'(pc0), 64'(2));

        // tx_req / tx_done ignored in GAP
        check("gap_txdata", 64'(txd), 64'(0));
        c = rd0_cnt + rd1_cnt;
        tx_req = 1'b1;
        tick(10);
        tx_req = 1'b0;
        check("gap_req_ignored", 64'(rd0_cnt + rd1_cnt - c), 64'(0));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("gap_done_ignored", 64'(pc0), 64'(2));
        tick(70);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_grant", 64'(grant), 64'(0));

        // Reset in the middle of a packet
        ch_en = 2'b01;
        exp_start_q.push_back(1'b0);
        wait_start();
        tick();
        for (int i = 0; i < 10; i++) begin
            tx_req = 1'b1;
            push_word(0);
            tick();
        end
        rst = 1'b1;
        push_word(0);
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0; ch_en = 2'b00;
        c = rd0_cnt + rd1_cnt;
        tick(5);
        tx_req = 1'b0;
        check("midrst_no_rd", 64'(rd0_cnt + rd1_cnt - c), 64'(0));
        check("midrst_sb_empty", 64'(exp_q.size()), 64'(0));

        // Round-robin from reset: 0,1,0,1
        lvl0 = 10'd300; lvl1 = 10'd300; ch_en = 2'b11;
        send_pkt(0);
        send_pkt(1);
        send_pkt(0);
        send_pkt(1);
        ch_en = 2'b00;
        tick(2);
        check("rr_cnt0", 64'(pc0), 64'(2));
        check("rr_cnt1", 64'(pc1), 64'(2));
        tick(80);
        check("sb_words_drained", 64'(exp_q.size()), 64'(0));
        check("sb_starts_drained", 64'(exp_start_q.size()), 64'(0));

        // Watchdog instance: first abort timing
        b_rst = 1'b0;
        tick();
        check("b_reset_to", 64'(b_to), 64'(0));
        b_lvl0 = 10'd256; b_en = 2'b01;
        wait_start_b();
        tick();
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (b_st == 2'd3) begin
                n = i;
                break;
            end
        end
        check("b_timeout_len", 64'(n), 64'(100));
        check("b_timeout_cnt1", 64'(b_to), 64'(1));
        check("b_timeout_pkt", 64'(b_pc0), 64'(0));
        b_tx_done = 1'b1;
        tick();
        b_tx_done = 1'b0;
        check("b_gap_done_ignored", 64'(b_pc0), 64'(0));

        // tx_done on the watchdog expiry cycle counts as completion
        wait_start_b();
        tick();
        tick(99);
        check("b_pre_expiry_state", 64'(b_st), 64'(2));
        b_tx_done = 1'b1;
        tick();
        b_tx_done = 1'b0;
        check("b_tie_state", 64'(b_st), 64'(3));
        check("b_tie_pkt", 64'(b_pc0), 64'(1));
        check("b_tie_to", 64'(b_to), 64'(1));

        // Saturation: 255 further aborts bring the total to 256
        prev = b_st;
        n = 0;
        for (int i = 0; i < 30000 && n < 255; i++) begin
            tick();
            if (prev == 2'd2 && b_st == 2'd3) n++;
            prev = b_st;
        end
        check("b_abort_events", 64'(n), 64'(255));
        check("b_to_saturated", 64'(b_to), 64'(255));
        check("b_pkt_unchanged", 64'(b_pc0), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
